// File: rtl/tick_gen_pkg.sv
// tick_gen_pkg: shared constants and helpers for the tick_gen clock-enable generator.
// Default divisors assume a 50 MHz master clock.
package tick_gen_pkg;

  // Default channel divisors: 25 MHz pixel, ~381 Hz 7-segment scan, 60 Hz render.
  localparam int unsigned DIV_PIX    = 2;
  localparam int unsigned DIV_SEG    = 131072;
  localparam int unsigned DIV_RENDER = 833333;

  // Upper bound on channels. It matches the 3-bit channel-select field.
  localparam int TICK_GEN_MAX_CH = 8;
  localparam int CH_IDX_W        = 3;

  // Packed reset divisors for the default 3-channel, 32-bit build. Channel 0 is in the LSB slice.
  localparam logic [95:0] DIV_INIT_DEFAULT = {32'(DIV_RENDER), 32'(DIV_SEG), 32'(DIV_PIX)};

  // A load may target only channels that exist in this build.
  function automatic logic ch_valid(input logic [CH_IDX_W-1:0] ch, input int num_ch);
    return int'(ch) < num_ch;
  endfunction

endpackage

// File: rtl/tick_gen_chan.sv
// tick_gen_chan: one divide-by-N channel. It produces a one-cycle tick enable and an optional
// 50%-duty level. The lvl flops exist only when TICK_GEN_LEVEL_EN is defined.
module tick_gen_chan
  import tick_gen_pkg::*;
#(
  parameter int               CNT_W   = 32,
  parameter logic [CNT_W-1:0] DIV_RST = CNT_W'(DIV_PIX)
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             en,
  input  logic             sync,
  input  logic             ld,
  input  logic [CNT_W-1:0] load_div,
  output logic             tick,
  output logic             lvl
);

  logic [CNT_W-1:0] div;
  logic [CNT_W-1:0] cnt;
  logic             run;
  logic             wrap;

  // A divisor of 0 parks the channel. In that state div-1 is never consulted.
  assign run  = en && (div != '0);
  assign wrap = run && (cnt == div - CNT_W'(1));

  // Divisor, counter and tick register. Load and sync take precedence over counting.
  // NOTE: state flops use non-blocking assignments so that every flop samples pre-edge values.
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      div  <= DIV_RST;
      cnt  <= '0;
      tick <= 1'b0;
    end else if (ld) begin
      div  <= load_div;
      cnt  <= '0;
      tick <= 1'b0;
    end else if (sync) begin
      cnt  <= '0;
      tick <= 1'b0;
    end else if (wrap) begin
      cnt  <= '0;
      tick <= 1'b1;
    end else if (run) begin
      cnt  <= cnt + CNT_W'(1);
      tick <= 1'b0;
    end else begin
      tick <= 1'b0;
    end
  end

`ifdef TICK_GEN_LEVEL_EN
  // Square-wave level: it toggles on every wrap and restarts low on load or sync.
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      lvl <= 1'b0;
    end else if (ld || sync) begin
      lvl <= 1'b0;
    end else if (wrap) begin
      lvl <= ~lvl;
    end
  end
`else
  assign lvl = 1'b0;
`endif

endmodule

// File: rtl/tick_gen.sv
// tick_gen: multi-channel clock-enable generator. All outputs stay on clk, and downstream logic
// qualifies its updates with tick[i]. Define TICK_GEN_LEVEL_EN to build the per-channel lvl outputs.
// Without that macro, lvl is constant 0.
module tick_gen
  import tick_gen_pkg::*;
#(
  parameter int                      NUM_CH   = 3,
  parameter int                      CNT_W    = 32,
  parameter logic [NUM_CH*CNT_W-1:0] DIV_INIT = DIV_INIT_DEFAULT
) (
  input  logic                clk,
  input  logic                clr,
  input  logic                en,
  input  logic                sync,
  input  logic                load,
  input  logic [CH_IDX_W-1:0] load_ch,
  input  logic [CNT_W-1:0]    load_div,
  output logic                load_ack,
  output logic [NUM_CH-1:0]   tick,
  output logic [NUM_CH-1:0]   lvl
);

  logic              load_ok;
  logic [NUM_CH-1:0] ld;

  // A load aimed at a channel that does not exist is dropped silently.
  assign load_ok = load && ch_valid(load_ch, NUM_CH);

  // Acknowledge pulse. It is raised on the same edge that applies the load.
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      load_ack <= 1'b0;
    end else begin
      load_ack <= load_ok;
    end
  end

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    assign ld[i] = load_ok && (load_ch == CH_IDX_W'(i));

    tick_gen_chan #(
      .CNT_W   (CNT_W),
      .DIV_RST (DIV_INIT[i*CNT_W +: CNT_W])
    ) u_chan (
      .clk      (clk),
      .clr      (clr),
      .en       (en),
      .sync     (sync),
      .ld       (ld[i]),
      .load_div (load_div),
      .tick     (tick[i]),
      .lvl      (lvl[i])
    );
  end

endmodule
